// File: rtl/reg_serial_reader_if.sv
// reg_serial_reader_if: parallel load side and serial valid/ready side of the register reader
interface reg_serial_reader_if #(parameter int WIDTH = 8);
    logic             l;
    logic [WIDTH-1:0] d;
    logic             sr;
    logic             so;
    logic             sv;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    modport master (output l, d, sr, input so, sv, busy, done, q);
    modport slave  (input l, d, sr, output so, sv, busy, done, q);
endinterface

// File: rtl/reg_serial_reader.sv
// reg_serial_reader: captures a register word on a load strobe and streams it LSB-first,
// followed by an even-parity bit, over a one-bit valid/ready link
module reg_serial_reader #(parameter int WIDTH = 8) (
    input logic c,
    input logic r,
    reg_serial_reader_if.slave b
);
    localparam int cw = $clog2(WIDTH);
    localparam logic [cw-1:0] last = cw'(WIDTH - 1);
    typedef enum logic [1:0] {s_idle, s_data, s_par, s_done} state_t;
    state_t st, nst;
    logic [WIDTH-1:0] sh, q;
    logic [cw-1:0] cnt;
    logic p, last_bit;
    always_comb begin
        last_bit = cnt == last;
        nst = st == s_idle ? (b.l ? s_data : s_idle) :
              st == s_data ? (b.sr && last_bit ? s_par : s_data) :
              st == s_par  ? (b.sr ? s_done : s_par) : s_idle;
        b.sv   = st == s_data || st == s_par;
        b.so   = st == s_data ? sh[0] : st == s_par ? p : 1'b0;
        b.busy = st != s_idle;
        b.done = st == s_done;
        b.q    = q;
    end
    // cnt saturates on the last data bit so it never exceeds WIDTH-1
    always_ff @(posedge c) begin
        if (r) begin
            st  <= s_idle;
            sh  <= '0;
            q   <= '0;
            cnt <= '0;
            p   <= 1'b0;
        end else begin
            st <= nst;
            if (st == s_idle && b.l) begin
                sh  <= b.d;
                q   <= b.d;
                p   <= ^b.d;
                cnt <= '0;
            end else if (st == s_data && b.sr) begin
                sh  <= {1'b0, sh[WIDTH-1:1]};
                cnt <= last_bit ? cnt : cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/reg_serial_reader.md
# reg_serial_reader

Parallel-load, serial-out reader for the bit-register datapath. It captures a WIDTH-bit word from a register bank on a load strobe and streams it LSB-first over a one-bit valid/ready link, followed by an even-parity bit. It sits on the read side of the register file: the register cells write and hold data, and this block carries the held word to a downstream serial consumer.

## Interface
- WIDTH, 8, data word width; legal range 2..32
- c  input  1  clock; all state updates on the rising edge
- r  input  1  reset, synchronous, active-high
- l  input  1  load strobe; sampled only in IDLE
- d  input  WIDTH  parallel word from the register bank
- sr  input  1  serial ready from the consumer
- so  output  1  serial data bit
- sv  output  1  serial valid
- busy  output  1  high from the load edge until the end of DONE
- done  output  1  one-cycle pulse after the parity bit is accepted
- q  output  WIDTH  shadow copy of the last loaded word; holds after the transfer

## Operation
- FSM states are IDLE, DATA, PAR and DONE. They are encoded in 2 bits. Unused encodings go to IDLE on the next edge.
- IDLE:
  - sv=0, busy=0, so=0.
  - If l=1, capture d into the shift register sh and into q. Compute p = XOR of d (even parity). Set cnt=0. Go to DATA.
- DATA:
  - sv=1, so=sh[0].
  - A bit transfers on a rising edge where sv=1 and sr=1. On transfer, sh shifts right by one (zero fill) and cnt increments.
  - On a transfer with cnt==WIDTH-1, go to PAR.
  - If sr=0, hold all state.
- PAR:
  - sv=1, so=p.
  - When the parity bit transfers, go to DONE.
- DONE:
  - sv=0, done=1, busy=1 for exactly one cycle, then go to IDLE.
- busy is high in DATA, PAR and DONE.
- l is ignored outside IDLE. A load in DONE is lost; the source must wait for busy=0.
- d is sampled only on the load edge. Changes to d during a transfer have no effect.
- cnt is $clog2(WIDTH) bits wide and never exceeds WIDTH-1. It resets to 0 on each load.
- Reset (r=1) at any rising edge, including mid-transfer:
  - state goes to IDLE; sh, q, cnt and p clear to 0.
  - so=0, sv=0, busy=0, done=0.
  - Any partial transfer is abandoned. No done pulse is produced.
- r takes priority over l and sr on the same edge.

## Timing
- Reset values: so=0, sv=0, busy=0, done=0, q=0.
- Latency from load to first valid:
  - l=1 sampled at edge N.
  - sv=1 and so=d[0] from edge N+1.
- Minimum transfer length with sr held high: WIDTH+1 cycles of sv=1, then one cycle of done.
  - Load edge N. Parity accepted at edge N+WIDTH+1. done is high in cycle N+WIDTH+1..N+WIDTH+2. busy falls at edge N+WIDTH+2.
- Back-to-back loads: the earliest next load is the edge at which busy=0 is first sampled. The bubble between transfers is 2 cycles (DONE plus IDLE).
- Valid/ready rules:
  - so and sv are registered and change only on edges.
  - sv never deasserts while a bit is pending and unaccepted.
  - so is stable while sv=1 and sr=0.
  - sr may be high at any time. It is ignored when sv=0.
- done and sv are never high in the same cycle.

## Test plan
- Reset: hold r=1 for 2 cycles with l=1 and d=8'hFF.
  - Required: so=0, sv=0, busy=0, done=0, q=8'h00. The load is not taken.
- Basic stream (WIDTH=8): load d=8'hA5 with sr=1 continuously.
  - Required: so sequence 1,0,1,0,0,1,0,1, then parity 0.
  - 9 cycles of sv=1, then done=1 for one cycle. q=8'hA5 afterwards.
- Backpressure: load d=8'h01 and toggle sr 1,0,0,1,...
  - Required: so and sv hold steady during sr=0 cycles.
  - Bit order is 1,0,0,0,0,0,0,0, then parity 1. Total transferred bits = 9.
- Ignored load: load 8'h3C, then pulse l=1 with d=8'hFF in DATA and in DONE.
  - Required: the stream is 3C LSB-first plus parity 0. q stays 8'h3C.
  - The next transfer starts only after a load in IDLE.
- Mid-transfer reset: load 8'hF0 and assert r after 4 bits are accepted.
  - Required: the next cycle has sv=0, busy=0, q=8'h00, and done never pulses.
  - A following load of 8'h0F streams 1,1,1,1,0,0,0,0, then parity 0.
- Back-to-back: load 8'h80, then load 8'h7F at the first edge with busy=0.
  - Required: two complete 9-bit streams, parity 1 then 1, separated by exactly 2 non-valid cycles.
